// File: rtl/risc_imem_32.sv
// Instruction-memory responder: fetch address in, instruction word out in request order, 2-cycle latency.
// A 3-entry response buffer absorbs decode stalls; req_ready comes from registered occupancy only.
module risc_imem_32 #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          IDX_W       = 8,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_addr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_instr,
   output logic [31:0]      rsp_addr,
   output logic [1:0]       rsp_fault,
   input  logic             prog_we,
   input  logic [IDX_W-1:0] prog_addr,
   input  logic [31:0]      prog_wdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_data;

   logic        inflight;
   logic [31:0] s1_addr;
   logic [1:0]  s1_fault;

   logic [31:0] buf_instr [3];
   logic [31:0] buf_addr  [3];
   logic [1:0]  buf_fault [3];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [1:0]  count;

   logic        accept;
   logic        pop;
   logic [1:0]  fault_dec;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Slots already promised (buffered + in flight) bound acceptance, so nothing can overflow.
   assign req_ready = reset & (({1'b0, count} + {2'b0, inflight}) < 3'd3);
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (count != 2'd0);
   assign pop       = rsp_valid & rsp_ready;

   always_comb begin
      fault_dec = 2'b00;
      if (req_addr[1:0] != 2'b00)
         fault_dec = 2'b01;
      else if (req_addr[31:IDX_W+2] != '0)
         fault_dec = 2'b10;
   end

   // Program writes ignore reset; a same-edge fetch of that word sees the old contents.
   always_ff @(posedge clk) begin
      if (prog_we)
         mem[prog_addr] <= prog_wdata;
      if (accept)
         rd_data <= mem[req_addr[IDX_W+1:2]];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         inflight <= 1'b0;
         count    <= 2'd0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
      end else begin
         inflight <= accept;
         if (accept) begin
            s1_addr  <= req_addr;
            s1_fault <= fault_dec;
         end
         if (inflight) begin
            buf_instr[wr_ptr] <= (s1_fault != 2'b00) ? NOP_INSTR : rd_data;
            buf_addr[wr_ptr]  <= s1_addr;
            buf_fault[wr_ptr] <= s1_fault;
            wr_ptr            <= next_ptr(wr_ptr);
         end
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   assign rsp_instr = rsp_valid ? buf_instr[rd_ptr] : 32'h0;
   assign rsp_addr  = rsp_valid ? buf_addr[rd_ptr]  : 32'h0;
   assign rsp_fault = rsp_valid ? buf_fault[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_risc_imem_32.sv
// Bench for risc_imem_32: directed scenarios plus random traffic against a queue-based reference.
module tb_risc_imem_32;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic [1:0]  rsp_fault;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_wdata;

   risc_imem_32 dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_instr  (rsp_instr),
      .rsp_addr   (rsp_addr),
      .rsp_fault  (rsp_fault),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [1:0]  fault;
      int          edge_no;
   } ent_t;

   localparam logic [31:0] NOP = 32'h00000013;

   int          errors = 0;
   int          checks = 0;
   int          edge_cnt = 0;
   logic [31:0] ref_mem [256];
   ent_t        q [$];
   logic [31:0] pop_instr [$];
   logic [31:0] pop_addr [$];
   logic [1:0]  pop_fault [$];
   logic        acc_flag;
   logic [31:0] mem255;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   // One clock: check outputs at negedge, advance the reference at posedge, release inputs 1 time unit later.
   task automatic cycle();
      logic        exp_valid;
      logic        exp_ready;
      logic        do_pop;
      ent_t        e;
      int unsigned wi;
      @(negedge clk);
      exp_valid = (q.size() > 0) && (q[0].edge_no + 2 <= edge_cnt);
      exp_ready = reset && (q.size() < 3);
      check_eq("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      check_eq("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      check_eq("rsp_instr", rsp_instr, exp_valid ? q[0].instr : 32'h0);
      check_eq("rsp_addr",  rsp_addr,  exp_valid ? q[0].addr  : 32'h0);
      check_eq("rsp_fault", {30'b0, rsp_fault}, exp_valid ? {30'b0, q[0].fault} : 32'h0);
      if (reset && rsp_valid === 1'b1 && rsp_ready) begin
         pop_instr.push_back(rsp_instr);
         pop_addr.push_back(rsp_addr);
         pop_fault.push_back(rsp_fault);
      end
      acc_flag = req_valid && exp_ready;
      do_pop   = exp_valid && rsp_ready;
      @(posedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         if (do_pop)
            void'(q.pop_front());
         if (acc_flag) begin
            e.addr    = req_addr;
            e.edge_no = edge_cnt;
            if (req_addr % 4 != 0)
               e.fault = 2'b01;
            else if (req_addr / 4 >= 256)
               e.fault = 2'b10;
            else
               e.fault = 2'b00;
            wi      = (req_addr / 4) % 256;
            e.instr = (e.fault != 2'b00) ? NOP : ref_mem[wi];
            q.push_back(e);
         end
      end
      if (prog_we)
         ref_mem[prog_addr] = prog_wdata;
      edge_cnt++;
      #1;
   endtask

   task automatic fetch(input logic [31:0] a);
      req_valid = 1'b1;
      req_addr  = a;
      for (int n = 0; n < 50; n++) begin
         cycle();
         if (acc_flag)
            return;
      end
      check_eq("fetch_timeout", {31'b0, acc_flag}, 32'd1);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      prog_we   = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic clear_pops();
      pop_instr.delete();
      pop_addr.delete();
      pop_fault.delete();
   endtask

   initial begin
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      rsp_ready  = 1'b0;
      prog_we    = 1'b0;
      prog_addr  = 8'h0;
      prog_wdata = 32'h0;
      @(posedge clk);
      #1;

      // Reset/idle and program load while held in reset
      for (int i = 0; i < 256; i++) begin
         prog_we    = 1'b1;
         prog_addr  = 8'(i);
         prog_wdata = $urandom;
         if (i == 0) prog_wdata = 32'h00500093;
         if (i == 1) prog_wdata = 32'h00A00113;
         if (i == 2) prog_wdata = 32'h002081B3;
         cycle();
      end
      prog_we = 1'b0;
      cycle();
      check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("rst_req_ready", {31'b0, req_ready}, 32'd0);
      reset = 1'b1;
      #1;
      check_eq("release_ready", {31'b0, req_ready}, 32'd1);
      mem255 = ref_mem[255];

      // Back-to-back fetches with a free consumer
      rsp_ready = 1'b1;
      clear_pops();
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      idle(4);
      check_eq("b2b_count", pop_instr.size(), 32'd3);
      if (pop_instr.size() == 3) begin
         check_eq("b2b_i0", pop_instr[0], 32'h00500093);
         check_eq("b2b_i1", pop_instr[1], 32'h00A00113);
         check_eq("b2b_i2", pop_instr[2], 32'h002081B3);
         check_eq("b2b_a2", pop_addr[2], 32'h8);
      end

      // Backpressure: fourth fetch stalls until the first pop
      rsp_ready = 1'b0;
      clear_pops();
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      req_addr = 32'hC;
      cycle();
      cycle();
      check_eq("bp_ready_low", {31'b0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
      fetch(32'hC);
      idle(5);
      check_eq("bp_count", pop_addr.size(), 32'd4);
      for (int i = 0; i < 4 && i < pop_addr.size(); i++)
         check_eq("bp_order", pop_addr[i], 32'(i * 4));

      // Fault decode
      clear_pops();
      fetch(32'h00000002);
      fetch(32'h00000400);
      fetch(32'h00000402);
      fetch(32'h000003FC);
      idle(4);
      check_eq("flt_count", pop_fault.size(), 32'd4);
      if (pop_fault.size() == 4) begin
         check_eq("flt_mis",  {30'b0, pop_fault[0]}, 32'd1);
         check_eq("flt_nop0", pop_instr[0], NOP);
         check_eq("flt_oor",  {30'b0, pop_fault[1]}, 32'd2);
         check_eq("flt_nop1", pop_instr[1], NOP);
         check_eq("flt_both", {30'b0, pop_fault[2]}, 32'd1);
         check_eq("flt_ok",   {30'b0, pop_fault[3]}, 32'd0);
         check_eq("flt_last", pop_instr[3], mem255);
         check_eq("flt_addr", pop_addr[1], 32'h00000400);
      end

      // Write/read collision on the same word
      clear_pops();
      prog_we    = 1'b1;
      prog_addr  = 8'd2;
      prog_wdata = 32'hAAAA5555;
      cycle();
      prog_wdata = 32'h5555AAAA;
      fetch(32'h8);
      prog_we = 1'b0;
      fetch(32'h8);
      idle(4);
      check_eq("col_count", pop_instr.size(), 32'd2);
      if (pop_instr.size() == 2) begin
         check_eq("col_old", pop_instr[0], 32'hAAAA5555);
         check_eq("col_new", pop_instr[1], 32'h5555AAAA);
      end

      // Reset with two buffered and one in flight
      rsp_ready = 1'b0;
      fetch(32'h10);
      fetch(32'h14);
      fetch(32'h18);
      req_valid = 1'b0;
      reset     = 1'b0;
      cycle();
      reset = 1'b1;
      check_eq("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
      rsp_ready = 1'b1;
      clear_pops();
      fetch(32'h4);
      idle(5);
      check_eq("mid_rst_count", pop_instr.size(), 32'd1);
      if (pop_instr.size() == 1) begin
         check_eq("mid_rst_instr", pop_instr[0], 32'h00A00113);
         check_eq("mid_rst_addr", pop_addr[0], 32'h4);
      end

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         reset     = ($urandom_range(0, 199) != 0);
         req_valid = $urandom_range(0, 1) == 1;
         r = $urandom_range(0, 9);
         if (r < 7)
            req_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
         else if (r == 7)
            req_addr = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
         else if (r == 8)
            req_addr = {20'b0, 10'($urandom_range(256, 1023)), 2'b00};
         else
            req_addr = $urandom;
         rsp_ready  = ($urandom_range(0, 3) != 0);
         prog_we    = ($urandom_range(0, 7) == 0);
         prog_addr  = 8'($urandom_range(0, 255));
         prog_wdata = $urandom;
         cycle();
      end
      reset     = 1'b1;
      rsp_ready = 1'b1;
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
